// File: rtl/fml_trace_capture.sv
// Producer side of the formal trace (vtx) interface. Watches coprocessor
// issue, CPR write-back and completion, keeps a shadow CPR file, and emits
// one registered record per retired instruction.
module fml_trace_capture #(
  parameter int          TIMEOUT   = 64,
  parameter logic [31:0] CPR_RESET = 32'h0
) (
  input  logic         vtx_clk,
  input  logic         vtx_reset,
  input  logic         cop_insn_valid,
  input  logic         cop_insn_ready,
  input  logic [31:0]  cop_insn_enc,
  input  logic [31:0]  cop_insn_rs1,
  input  logic         cop_cpr_wen0,
  input  logic [3:0]   cop_cpr_waddr0,
  input  logic [31:0]  cop_cpr_wdata0,
  input  logic         cop_cpr_wen1,
  input  logic [3:0]   cop_cpr_waddr1,
  input  logic [31:0]  cop_cpr_wdata1,
  input  logic         cop_insn_finish,
  input  logic [2:0]   cop_insn_result,
  input  logic         cop_gpr_wen,
  input  logic [4:0]   cop_gpr_waddr,
  input  logic [31:0]  cop_gpr_wdata,
  output logic         vtx_valid,
  output logic [31:0]  vtx_instr_enc,
  output logic [31:0]  vtx_instr_rs1,
  output logic [2:0]   vtx_instr_result,
  output logic         vtx_instr_wen,
  output logic [4:0]   vtx_instr_waddr,
  output logic [31:0]  vtx_instr_wdata,
  output logic [511:0] vtx_cprs_pre,
  output logic [511:0] vtx_cprs_post,
  output logic         vtx_timeout,
  output logic         vtx_proto_err
);

  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUSY, EMIT} state_t;

  state_t            state, state_nx;
  logic              pend, pend_nx;     // next instruction already issued during EMIT
  logic              issue, inflight;
  logic              take_issue, take_finish, err;
  logic [15:0][31:0] shadow, shadow_nx;
  logic [31:0]       cur_enc, cur_rs1;
  logic [511:0]      cur_pre;
  logic [WW-1:0]     wdog;

  assign issue     = cop_insn_valid & cop_insn_ready;
  assign vtx_valid = (state == EMIT);

  // Shadow CPR view including this cycle's writes; port 1 applied last so it wins.
  always_comb begin
    shadow_nx = shadow;
    if (cop_cpr_wen0) shadow_nx[cop_cpr_waddr0] = cop_cpr_wdata0;
    if (cop_cpr_wen1) shadow_nx[cop_cpr_waddr1] = cop_cpr_wdata1;
  end

  // Next state, capture strobes and protocol-violation detection.
  always_comb begin
    state_nx    = state;
    pend_nx     = pend;
    take_issue  = 1'b0;
    take_finish = 1'b0;
    err         = 1'b0;
    // An instruction is outstanding in BUSY, or in EMIT when a back-to-back
    // issue landed in the finish cycle.
    inflight    = (state == BUSY) || ((state == EMIT) && pend);
    if (inflight) begin
      if (cop_insn_finish) begin
        take_finish = 1'b1;
        state_nx    = EMIT;
        pend_nx     = issue;
        take_issue  = issue;
      end else begin
        err      = issue;
        state_nx = BUSY;
        pend_nx  = 1'b0;
      end
    end else begin
      err     = cop_insn_finish;
      pend_nx = 1'b0;
      if (issue) begin
        take_issue = 1'b1;
        state_nx   = BUSY;
      end else begin
        state_nx   = IDLE;
      end
    end
    if ((state == IDLE) && (cop_cpr_wen0 || cop_cpr_wen1)) err = 1'b1;
  end

  // State register.
  always_ff @(posedge vtx_clk) begin
    if (vtx_reset) begin
      state <= IDLE;
      pend  <= 1'b0;
    end else begin
      state <= state_nx;
      pend  <= pend_nx;
    end
  end

  // Shadow file, in-flight instruction, watchdog, sticky flags and record fields.
  always_ff @(posedge vtx_clk) begin
    if (vtx_reset) begin
      shadow           <= {16{CPR_RESET}};
      cur_enc          <= '0;
      cur_rs1          <= '0;
      cur_pre          <= {16{CPR_RESET}};
      wdog             <= '0;
      vtx_timeout      <= 1'b0;
      vtx_proto_err    <= 1'b0;
      vtx_instr_enc    <= '0;
      vtx_instr_rs1    <= '0;
      vtx_instr_result <= '0;
      vtx_instr_wen    <= 1'b0;
      vtx_instr_waddr  <= '0;
      vtx_instr_wdata  <= '0;
      vtx_cprs_pre     <= {16{CPR_RESET}};
      vtx_cprs_post    <= {16{CPR_RESET}};
    end else begin
      shadow <= shadow_nx;
      if (err) vtx_proto_err <= 1'b1;
      if (take_issue) begin
        cur_enc <= cop_insn_enc;
        cur_rs1 <= cop_insn_rs1;
        cur_pre <= shadow_nx;
        wdog    <= '0;
      end else if (inflight && !cop_insn_finish) begin
        if (int'(wdog) < TIMEOUT) wdog <= wdog + 1'b1;
        if (int'(wdog) + 1 >= TIMEOUT) vtx_timeout <= 1'b1;
      end
      // Record is loaded from the pre-issue copy, so a same-cycle issue is safe.
      if (take_finish) begin
        vtx_instr_enc    <= cur_enc;
        vtx_instr_rs1    <= cur_rs1;
        vtx_instr_result <= cop_insn_result;
        vtx_instr_wen    <= cop_gpr_wen;
        vtx_instr_waddr  <= cop_gpr_waddr;
        vtx_instr_wdata  <= cop_gpr_wdata;
        vtx_cprs_pre     <= cur_pre;
        vtx_cprs_post    <= shadow_nx;
      end
    end
  end

endmodule

// File: tb/tb_fml_trace_capture.sv
// Directed bench for fml_trace_capture: stimulus pushes expected records,
// a negedge monitor pops and compares whenever vtx_valid is seen.
module tb_fml_trace_capture;

  localparam int          TO      = 8;
  localparam logic [31:0] CPR_RST = 32'h0;

  logic         vtx_clk, vtx_reset;
  logic         cop_insn_valid, cop_insn_ready;
  logic [31:0]  cop_insn_enc, cop_insn_rs1;
  logic         cop_cpr_wen0, cop_cpr_wen1;
  logic [3:0]   cop_cpr_waddr0, cop_cpr_waddr1;
  logic [31:0]  cop_cpr_wdata0, cop_cpr_wdata1;
  logic         cop_insn_finish;
  logic [2:0]   cop_insn_result;
  logic         cop_gpr_wen;
  logic [4:0]   cop_gpr_waddr;
  logic [31:0]  cop_gpr_wdata;
  logic         vtx_valid;
  logic [31:0]  vtx_instr_enc, vtx_instr_rs1;
  logic [2:0]   vtx_instr_result;
  logic         vtx_instr_wen;
  logic [4:0]   vtx_instr_waddr;
  logic [31:0]  vtx_instr_wdata;
  logic [511:0] vtx_cprs_pre, vtx_cprs_post;
  logic         vtx_timeout, vtx_proto_err;

  fml_trace_capture #(.TIMEOUT(TO), .CPR_RESET(CPR_RST)) dut (
    .vtx_clk(vtx_clk), .vtx_reset(vtx_reset),
    .cop_insn_valid(cop_insn_valid), .cop_insn_ready(cop_insn_ready),
    .cop_insn_enc(cop_insn_enc), .cop_insn_rs1(cop_insn_rs1),
    .cop_cpr_wen0(cop_cpr_wen0), .cop_cpr_waddr0(cop_cpr_waddr0), .cop_cpr_wdata0(cop_cpr_wdata0),
    .cop_cpr_wen1(cop_cpr_wen1), .cop_cpr_waddr1(cop_cpr_waddr1), .cop_cpr_wdata1(cop_cpr_wdata1),
    .cop_insn_finish(cop_insn_finish), .cop_insn_result(cop_insn_result),
    .cop_gpr_wen(cop_gpr_wen), .cop_gpr_waddr(cop_gpr_waddr), .cop_gpr_wdata(cop_gpr_wdata),
    .vtx_valid(vtx_valid), .vtx_instr_enc(vtx_instr_enc), .vtx_instr_rs1(vtx_instr_rs1),
    .vtx_instr_result(vtx_instr_result), .vtx_instr_wen(vtx_instr_wen),
    .vtx_instr_waddr(vtx_instr_waddr), .vtx_instr_wdata(vtx_instr_wdata),
    .vtx_cprs_pre(vtx_cprs_pre), .vtx_cprs_post(vtx_cprs_post),
    .vtx_timeout(vtx_timeout), .vtx_proto_err(vtx_proto_err)
  );

  typedef struct {
    logic [31:0]  enc, rs1;
    logic [2:0]   res;
    logic         wen;
    logic [4:0]   waddr;
    logic [31:0]  wdata;
    logic [511:0] pre, post;
    int           cyc;
  } rec_t;

  rec_t              q[$];
  logic [15:0][31:0] m;         // expected shadow CPR contents
  int                cyc = 0;
  int                n_chk = 0, n_fail = 0, n_push = 0, n_seen = 0;
  logic [511:0]      pre_a, pre_b, post_a;

  initial vtx_clk = 1'b0;
  always #5 vtx_clk = ~vtx_clk;
  always @(posedge vtx_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] snap();
    return m;
  endfunction

  task automatic clear_in();
    cop_insn_valid = 0; cop_insn_ready = 0; cop_insn_enc = 0; cop_insn_rs1 = 0;
    cop_cpr_wen0 = 0; cop_cpr_waddr0 = 0; cop_cpr_wdata0 = 0;
    cop_cpr_wen1 = 0; cop_cpr_waddr1 = 0; cop_cpr_wdata1 = 0;
    cop_insn_finish = 0; cop_insn_result = 0;
    cop_gpr_wen = 0; cop_gpr_waddr = 0; cop_gpr_wdata = 0;
  endtask

  // Fold this cycle's writes into the expected shadow, clock once, clear pulses.
  task automatic tick();
    if (vtx_reset) m = {16{CPR_RST}};
    else begin
      if (cop_cpr_wen0) m[cop_cpr_waddr0] = cop_cpr_wdata0;
      if (cop_cpr_wen1) m[cop_cpr_waddr1] = cop_cpr_wdata1;
    end
    @(posedge vtx_clk); #1;
    clear_in();
  endtask

  task automatic issue(input logic [31:0] enc, input logic [31:0] rs1);
    cop_insn_valid = 1; cop_insn_ready = 1; cop_insn_enc = enc; cop_insn_rs1 = rs1;
  endtask

  task automatic finish(input logic [2:0] res, input logic wen, input logic [4:0] wa, input logic [31:0] wd);
    cop_insn_finish = 1; cop_insn_result = res;
    cop_gpr_wen = wen; cop_gpr_waddr = wa; cop_gpr_wdata = wd;
  endtask

  // Called right after the finish tick: the record must be visible this cycle.
  task automatic push(input logic [31:0] enc, input logic [31:0] rs1, input logic [2:0] res,
                      input logic wen, input logic [4:0] wa, input logic [31:0] wd,
                      input logic [511:0] pre, input logic [511:0] post);
    rec_t r;
    r.enc = enc; r.rs1 = rs1; r.res = res; r.wen = wen; r.waddr = wa; r.wdata = wd;
    r.pre = pre; r.post = post; r.cyc = cyc;
    q.push_back(r);
    n_push++;
  endtask

  // Monitor: every strobe must match the oldest expected record.
  always @(negedge vtx_clk) begin
    if (vtx_valid === 1'b1) begin
      n_seen++;
      if (q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_valid: got vtx_valid=1 enc=%0h at cycle %0d, required no record", vtx_instr_enc, cyc);
      end else begin
        rec_t r;
        r = q.pop_front();
        chk("latency", 512'(cyc), 512'(r.cyc));
        chk("enc_rs1", {vtx_instr_enc, vtx_instr_rs1}, {r.enc, r.rs1});
        chk("result_gpr", {vtx_instr_result, vtx_instr_wen, vtx_instr_waddr, vtx_instr_wdata},
                          {r.res, r.wen, r.waddr, r.wdata});
        chk("cprs_pre", vtx_cprs_pre, r.pre);
        chk("cprs_post", vtx_cprs_post, r.post);
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, 512'(vtx_valid), 512'(0));
    chk({tag, "_fields"}, {vtx_instr_enc, vtx_instr_rs1, vtx_instr_result, vtx_instr_wen,
                           vtx_instr_waddr, vtx_instr_wdata}, '0);
    chk({tag, "_pre"}, vtx_cprs_pre, {16{CPR_RST}});
    chk({tag, "_post"}, vtx_cprs_post, {16{CPR_RST}});
    chk({tag, "_timeout"}, 512'(vtx_timeout), 512'(0));
  endtask

  initial begin
    clear_in();
    m = {16{CPR_RST}};
    vtx_reset = 1;
    tick(); tick();
    vtx_reset = 0;
    chk_reset_outputs("rst");
    chk("rst_proto", 512'(vtx_proto_err), 512'(0));

    // 1: basic instruction, port-0 write in BUSY
    issue(32'h0000_1234, 32'd5); tick();
    pre_a = snap();
    cop_cpr_wen0 = 1; cop_cpr_waddr0 = 3; cop_cpr_wdata0 = 32'hDEAD_BEEF; tick();
    finish(3'd0, 1'b1, 5'd7, 32'd9); tick();
    push(32'h1234, 32'd5, 3'd0, 1'b1, 5'd7, 32'd9, pre_a, snap());
    chk("t1_post3", 512'(m[3]), 512'(32'hDEAD_BEEF));
    tick();

    // 2: dual write to c5 in the finish cycle, port 1 wins
    issue(32'h0000_0002, 32'h22); tick();
    pre_a = snap();
    finish(3'd3, 1'b0, 5'd0, 32'd0);
    cop_cpr_wen0 = 1; cop_cpr_waddr0 = 5; cop_cpr_wdata0 = 32'd1;
    cop_cpr_wen1 = 1; cop_cpr_waddr1 = 5; cop_cpr_wdata1 = 32'd2; tick();
    push(32'h2, 32'h22, 3'd3, 1'b0, 5'd0, 32'd0, pre_a, snap());
    chk("t2_post5", 512'(m[5]), 512'(32'd2));
    tick();

    // 3: finish + issue in the same cycle, next finishes two cycles later
    issue(32'h0000_0003, 32'h33); tick();
    pre_a = snap();
    finish(3'd1, 1'b1, 5'd1, 32'hAAAA);
    cop_cpr_wen0 = 1; cop_cpr_waddr0 = 0; cop_cpr_wdata0 = 32'h1111;
    issue(32'h0000_0004, 32'h44); tick();
    post_a = snap();
    push(32'h3, 32'h33, 3'd1, 1'b1, 5'd1, 32'hAAAA, pre_a, post_a);
    cop_cpr_wen1 = 1; cop_cpr_waddr1 = 9; cop_cpr_wdata1 = 32'h9999; tick();
    finish(3'd2, 1'b0, 5'd0, 32'd0); tick();
    push(32'h4, 32'h44, 3'd2, 1'b0, 5'd0, 32'd0, post_a, snap());
    tick();

    // 3b: back-to-back finishes produce consecutive strobes
    issue(32'h0000_0005, 32'h55); tick();
    pre_a = snap();
    finish(3'd0, 1'b1, 5'd2, 32'h5); issue(32'h0000_0006, 32'h66); tick();
    post_a = snap();
    push(32'h5, 32'h55, 3'd0, 1'b1, 5'd2, 32'h5, pre_a, post_a);
    finish(3'd4, 1'b1, 5'd3, 32'h6); tick();
    push(32'h6, 32'h66, 3'd4, 1'b1, 5'd3, 32'h6, post_a, snap());
    tick(); tick();
    chk("t3_proto", 512'(vtx_proto_err), 512'(0));

    // 4: watchdog
    issue(32'h0000_0007, 32'h77); tick();
    pre_a = snap();
    repeat (6) tick();
    chk("t4_timeout_early", 512'(vtx_timeout), 512'(0));
    repeat (4) tick();
    chk("t4_timeout_set", 512'(vtx_timeout), 512'(1));
    finish(3'd5, 1'b0, 5'd0, 32'd0); tick();
    push(32'h7, 32'h77, 3'd5, 1'b0, 5'd0, 32'd0, pre_a, snap());
    tick(); tick();
    chk("t4_timeout_sticky", 512'(vtx_timeout), 512'(1));
    chk("t4_proto", 512'(vtx_proto_err), 512'(0));

    // 5: CPR write in IDLE, stray finish, shadow still updated
    cop_cpr_wen0 = 1; cop_cpr_waddr0 = 2; cop_cpr_wdata0 = 32'h2222; tick();
    chk("t5_proto_write", 512'(vtx_proto_err), 512'(1));
    finish(3'd6, 1'b1, 5'd4, 32'h4); tick();
    tick(); tick();
    issue(32'h0000_0008, 32'h88); tick();
    pre_a = snap();
    chk("t5_model_c2", 512'(m[2]), 512'(32'h2222));
    finish(3'd7, 1'b0, 5'd0, 32'd0); tick();
    push(32'h8, 32'h88, 3'd7, 1'b0, 5'd0, 32'd0, pre_a, snap());
    tick();

    // 6: reset while BUSY, then a finish with nothing pending
    vtx_reset = 1; tick(); vtx_reset = 0;
    chk("t6_proto_cleared", 512'(vtx_proto_err), 512'(0));
    issue(32'h0000_0009, 32'h99); tick();
    cop_cpr_wen0 = 1; cop_cpr_waddr0 = 4; cop_cpr_wdata0 = 32'h4444; tick();
    vtx_reset = 1; tick(); vtx_reset = 0;
    finish(3'd1, 1'b1, 5'd5, 32'h5); tick();
    tick();
    chk_reset_outputs("t6");
    chk("t6_proto", 512'(vtx_proto_err), 512'(1));
    issue(32'h0000_000A, 32'hAA); tick();
    pre_b = snap();
    finish(3'd2, 1'b1, 5'd6, 32'h6); tick();
    push(32'hA, 32'hAA, 3'd2, 1'b1, 5'd6, 32'h6, pre_b, snap());
    chk("t6_shadow_reset", pre_b, {16{CPR_RST}});
    tick(); tick();

    chk("queue_empty", 512'(q.size()), 512'(0));
    chk("record_count", 512'(n_seen), 512'(n_push));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fml_trace_capture.md
Name: fml_trace_capture

Overview:
- Producer side of the formal verification trace (vtx) interface.
- Sits in the formal wrapper beside the coprocessor. Observes instruction issue, CPR write-back and instruction completion.
- Keeps a shadow copy of the 16-entry CPR file. Emits one registered vtx record per retired instruction: encoding, rs1, result code, GPR write-back, CPR pre- and post-state.
- Instruction checker modules consume this record.

Parameters:
- TIMEOUT, 64, max cycles from issue to finish before vtx_timeout is set (≥2).
- CPR_RESET, 32'h0, reset value of every shadow CPR word.

Ports:
- vtx_clk  input  1  sole clock.
- vtx_reset  input  1  synchronous, active-high reset.
- cop_insn_valid  input  1  coprocessor instruction offered.
- cop_insn_ready  input  1  coprocessor accepts; issue = valid&&ready.
- cop_insn_enc  input  32  instruction encoding, sampled at issue.
- cop_insn_rs1  input  32  GPR rs1 value, sampled at issue.
- cop_cpr_wen0  input  1  CPR write port 0 enable.
- cop_cpr_waddr0  input  4  port 0 address.
- cop_cpr_wdata0  input  32  port 0 data.
- cop_cpr_wen1, cop_cpr_waddr1, cop_cpr_wdata1  input  1/4/32  CPR write port 1.
- cop_insn_finish  input  1  one-cycle completion pulse.
- cop_insn_result  input  3  result/exception code, valid with finish.
- cop_gpr_wen  input  1  GPR write-back enable, valid with finish.
- cop_gpr_waddr  input  5  GPR write-back address, valid with finish.
- cop_gpr_wdata  input  32  GPR write-back data, valid with finish.
- vtx_valid  output  1  one-cycle record strobe.
- vtx_instr_enc, vtx_instr_rs1  output  32 each  record fields.
- vtx_instr_result  output  3  record field.
- vtx_instr_wen, vtx_instr_waddr, vtx_instr_wdata  output  1/5/32  record fields.
- vtx_cprs_pre, vtx_cprs_post  output  512 each  CPR snapshots; word i at [32i+31:32i].
- vtx_timeout  output  1  sticky: finish not seen within TIMEOUT.
- vtx_proto_err  output  1  sticky protocol violation.

Behaviour:
- Reset (sync, vtx_reset=1 at a vtx_clk edge):
  - State to IDLE.
  - All vtx_* outputs to 0, except vtx_cprs_pre and vtx_cprs_post, which go to CPR_RESET replicated.
  - Shadow CPRs to CPR_RESET; watchdog to 0.
  - Reset mid-instruction abandons it; no record is emitted.
- Shadow CPR update: every cycle, independent of state.
  - Port 0 is applied first, then port 1.
  - Same address on both ports in one cycle: port 1 wins.
- States:
  - IDLE: on issue, latch enc/rs1 and snapshot pre-state; go BUSY. The pre-state is the shadow as updated by writes in that same cycle.
  - BUSY: watchdog increments each cycle. On finish, latch result and GPR fields, capture post-state (shadow including writes in the finish cycle), and go EMIT.
  - EMIT (one cycle): vtx_valid=1 with all record fields stable. Then go IDLE, or go BUSY if an issue occurred in the EMIT cycle.
- Back-to-back issue:
  - Issue in the same cycle as finish (BUSY) is legal. The new pre-state equals the finishing instruction's post-state; go EMIT with the next instruction pending, then BUSY.
  - Issue in the EMIT cycle is also legal.
- Output latency: vtx_valid rises exactly one cycle after the finish pulse and is never high two consecutive cycles unless finishes are consecutive.
- Hold rule: record fields hold their values until the next vtx_valid.
- Watchdog: when the count reaches TIMEOUT while still BUSY, vtx_timeout=1 (sticky until reset). The FSM remains BUSY.
- vtx_proto_err=1 (sticky) when any of these occurs:
  - issue in BUSY without a same-cycle finish;
  - finish in IDLE or EMIT with no instruction pending;
  - any CPR write while IDLE.
- The offending event is otherwise ignored, except that CPR writes still update the shadow.
- Result field is 3 bits; no width conversion. Fields are copied unmodified.

Test Plan:
1. Reset, then issue enc=32'h0000_1234, rs1=5. Port0 writes c3=32'hDEAD_BEEF one cycle later; finish with result=0, gpr wen=1, waddr=7, wdata=9 at the following cycle. Required: vtx_valid one cycle after finish; pre[3]=0; post[3]=DEADBEEF; waddr=7; wdata=9.
2. Dual write in the finish cycle: port0 c5=1 and port1 c5=2. Required: post[5]=2; all other words equal to pre.
3. Finish and new issue in the same cycle. Required: two vtx_valid pulses; the second record's pre equals the first record's post; proto_err stays 0.
4. TIMEOUT=8: issue and withhold finish for 8 cycles. Required: vtx_timeout=1, stays 1 after a later finish; the record is still emitted.
5. CPR write while IDLE, then a finish with nothing pending. Required: vtx_proto_err=1; no vtx_valid; shadow updated (next record's pre reflects the write).
6. vtx_reset asserted while BUSY, then finish pulsed. Required: no vtx_valid; outputs at reset values; proto_err=1 (finish in IDLE).
